// File: rtl/aes_state_unloader.sv
// Byte-serial output stage: accepts a 128-bit AES state block and streams it MSB byte first.
// Optional double buffering (back-to-back blocks, no bubble) is enabled by defining AES_UNLOAD_DBUF_EN.
module aes_state_unloader #(
  parameter int BLOCK_BYTES = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [8*BLOCK_BYTES-1:0]       in_block,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [7:0]                     out_byte,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic [$clog2(BLOCK_BYTES)-1:0] out_index,
  output logic                           block_done,
  output logic                           state_dbg
);

  localparam int BW = 8 * BLOCK_BYTES;
  localparam int CW = $clog2(BLOCK_BYTES);
  localparam logic [CW-1:0] LAST     = CW'(BLOCK_BYTES - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(BLOCK_BYTES - 2);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // the producer holds data and valid until that edge, and valid never waits on ready.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state;
  logic [BW-1:0]   shreg;
  logic [CW-1:0]   count;

`ifdef AES_UNLOAD_DBUF_EN
  logic [BW-1:0]   hold;
  logic            hold_full;
`endif

  // Outputs come straight from flops; out_ready only steers next-state logic.
  assign out_byte  = shreg[BW-1 -: 8];
  assign out_index = count;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      count      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      block_done <= 1'b0;
`ifdef AES_UNLOAD_DBUF_EN
      hold       <= '0;
      hold_full  <= 1'b0;
`endif
    end else begin
      block_done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg     <= in_block;
            count     <= '0;
            state     <= SHIFT;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
`ifdef AES_UNLOAD_DBUF_EN
            in_ready  <= 1'b1;
`else
            in_ready  <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (out_ready) begin
            if (count != LAST) begin
              shreg    <= {shreg[BW-9:0], 8'h00};
              count    <= count + CW'(1);
              out_last <= (count == PRE_LAST);
            end else begin
              block_done <= 1'b1;
              count      <= '0;
              out_last   <= 1'b0;
`ifdef AES_UNLOAD_DBUF_EN
              if (hold_full) begin
                shreg     <= hold;
                hold_full <= 1'b0;
                in_ready  <= 1'b1;
              end else if (in_valid) begin
                // Hold is empty so in_ready is high: take the new block directly.
                shreg    <= in_block;
                in_ready <= 1'b1;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
              end
`else
              state     <= IDLE;
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
`endif
            end
          end
`ifdef AES_UNLOAD_DBUF_EN
          // A block arriving mid-stream parks in the hold register until the last byte leaves.
          if (in_valid && in_ready && !(out_ready && (count == LAST))) begin
            hold      <= in_block;
            hold_full <= 1'b1;
            in_ready  <= 1'b0;
          end
`endif
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
